// File: rtl/cic_interpolator_variable_ahb.sv
// Variable-ratio CIC interpolator: N combs at the input rate, zero-stuffing by R and
// N integrators at the output rate. Ratio, shift and enable sit behind an AHB-Lite slave.
module cic_interpolator_variable_ahb #(
  parameter int unsigned DW   = 16,
  parameter int unsigned N    = 3,
  parameter int unsigned RMAX = 64,
  parameter int unsigned GW   = DW + N * $clog2(RMAX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic signed [DW-1:0] tdata_s,
  input  logic                 tvalid_s,
  output logic                 tready_s,
  output logic signed [DW-1:0] tdata_m,
  output logic                 tvalid_m,
  input  logic                 tready_m,
  input  logic [31:0]          haddr_s,
  input  logic [2:0]           hburst_s,
  input  logic [2:0]           hsize_s,
  input  logic [1:0]           htrans_s,
  input  logic [31:0]          hwdata_s,
  input  logic                 hwrite_s,
  output logic [31:0]          hrdata_s,
  output logic                 hreadyout_s,
  output logic                 hresp_s,
  input  logic                 hsel_s
);

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrRatio  = 2'd1;
  localparam logic [1:0] AddrShift  = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;
  localparam logic [7:0] RmaxVal    = 8'(RMAX);

  localparam logic signed [GW-1:0] SatMax = {{(GW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [GW-1:0] SatMin = {{(GW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Control registers and AHB pipeline
  logic       enable_q;
  logic [7:0] ratio_q;
  logic [5:0] shift_q;
  logic       ahb_wr_q;
  logic       ahb_rd_q;
  logic [1:0] ahb_addr_q;
  logic [7:0] ratio_wr;
  logic       clr;

  // Datapath state
  logic signed [GW-1:0] comb_prev_q [N];
  logic signed [GW-1:0] comb_y      [N];
  logic signed [GW-1:0] comb_out_q;
  logic signed [GW-1:0] integ_q     [N];
  logic signed [GW-1:0] integ_d     [N];
  logic signed [GW-1:0] integ_in;
  logic signed [GW-1:0] integ_shr;
  logic signed [GW-1:0] x_ext;
  logic [7:0]           phase_q;
  logic [7:0]           r_act_q;
  logic                 pend_q;
  logic                 tvalid_q;
  logic signed [DW-1:0] tdata_q;
  logic signed [DW-1:0] sat_val;
  logic                 last_phase;
  logic                 step;
  logic                 accept;

  logic unused_ahb;
  assign unused_ahb = ^{hburst_s, hsize_s, haddr_s[31:4], haddr_s[1:0], htrans_s[0],
                        hwdata_s[31:8]};

  assign hreadyout_s = 1'b1;
  assign hresp_s     = 1'b0;
  assign tvalid_m    = tvalid_q;
  assign tdata_m     = tdata_q;

  always_comb begin
    ratio_wr = hwdata_s[7:0];
    if (hwdata_s[7:0] == 8'd0) begin
      ratio_wr = 8'd1;
    end else if (hwdata_s[7:0] > RmaxVal) begin
      ratio_wr = RmaxVal;
    end
  end

  // Clear is a write-only pulse that acts on the same edge the write lands.
  assign clr = ahb_wr_q & (ahb_addr_q == AddrCtrl) & hwdata_s[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q   <= 1'b0;
      ratio_q    <= 8'd1;
      shift_q    <= 6'd0;
      ahb_wr_q   <= 1'b0;
      ahb_rd_q   <= 1'b0;
      ahb_addr_q <= 2'd0;
    end else begin
      ahb_wr_q <= hsel_s & htrans_s[1] & hwrite_s;
      ahb_rd_q <= hsel_s & htrans_s[1] & ~hwrite_s;
      if (hsel_s & htrans_s[1]) begin
        ahb_addr_q <= haddr_s[3:2];
      end
      if (ahb_wr_q) begin
        case (ahb_addr_q)
          AddrCtrl:  enable_q <= hwdata_s[0];
          AddrRatio: ratio_q  <= ratio_wr;
          AddrShift: shift_q  <= hwdata_s[5:0];
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    hrdata_s = 32'd0;
    if (ahb_rd_q) begin
      case (ahb_addr_q)
        AddrCtrl:   hrdata_s[0]    = enable_q;
        AddrRatio:  hrdata_s[7:0]  = ratio_q;
        AddrShift:  hrdata_s[5:0]  = shift_q;
        AddrStatus: begin
          hrdata_s[0]    = pend_q;
          hrdata_s[15:8] = phase_q;
        end
        default:    hrdata_s = 32'd0;
      endcase
    end
  end

  // Handshake: a new sample may enter when idle or on the final phase of the current one.
  assign last_phase = (phase_q == r_act_q - 8'd1);
  assign step       = ce & pend_q & (~tvalid_q | tready_m);
  assign tready_s   = enable_q & ce & ~clr & (~pend_q | (step & last_phase));
  assign accept     = tvalid_s & tready_s;

  assign x_ext = {{(GW-DW){tdata_s[DW-1]}}, tdata_s};

  always_comb begin
    comb_y[0] = x_ext - comb_prev_q[0];
    for (int unsigned k = 1; k < N; k++) begin
      comb_y[k] = comb_y[k-1] - comb_prev_q[k];
    end
  end

  // Integrators cascade within one step so the output reflects this phase's input.
  always_comb begin
    integ_in   = (phase_q == 8'd0) ? comb_out_q : '0;
    integ_d[0] = integ_q[0] + integ_in;
    for (int unsigned k = 1; k < N; k++) begin
      integ_d[k] = integ_q[k] + integ_d[k-1];
    end
    integ_shr = integ_d[N-1] >>> shift_q;
    if (integ_shr > SatMax) begin
      sat_val = {1'b0, {(DW-1){1'b1}}};
    end else if (integ_shr < SatMin) begin
      sat_val = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_val = integ_shr[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int unsigned k = 0; k < N; k++) begin
        comb_prev_q[k] <= '0;
        integ_q[k]     <= '0;
      end
      comb_out_q <= '0;
      phase_q    <= 8'd0;
      r_act_q    <= 8'd1;
      pend_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
    end else if (ce) begin
      if (accept) begin
        comb_prev_q[0] <= x_ext;
        for (int unsigned k = 1; k < N; k++) begin
          comb_prev_q[k] <= comb_y[k-1];
        end
        comb_out_q <= comb_y[N-1];
        r_act_q    <= ratio_q;
      end
      if (step) begin
        for (int unsigned k = 0; k < N; k++) begin
          integ_q[k] <= integ_d[k];
        end
        phase_q  <= last_phase ? 8'd0 : phase_q + 8'd1;
        tvalid_q <= 1'b1;
        tdata_q  <= sat_val;
      end else if (tready_m) begin
        tvalid_q <= 1'b0;
      end
      if (accept) begin
        pend_q <= 1'b1;
      end else if (step && last_phase) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator_variable_ahb.sv
// Bench for the variable-ratio CIC interpolator: register vectors, directed corner
// sequences and random streams checked against a convolution model of the filter.
module tb_cic_interpolator_variable_ahb;

  localparam int DW   = 16;
  localparam int N    = 3;
  localparam int RMAX = 64;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 ce = 1'b1;
  logic signed [DW-1:0] tdata_s = '0;
  logic                 tvalid_s = 1'b0;
  logic                 tready_s;
  logic signed [DW-1:0] tdata_m;
  logic                 tvalid_m;
  logic                 tready_m = 1'b1;
  logic [31:0]          haddr_s = '0;
  logic [2:0]           hburst_s = '0;
  logic [2:0]           hsize_s = 3'd2;
  logic [1:0]           htrans_s = '0;
  logic [31:0]          hwdata_s = '0;
  logic                 hwrite_s = 1'b0;
  logic [31:0]          hrdata_s;
  logic                 hreadyout_s;
  logic                 hresp_s;
  logic                 hsel_s = 1'b0;

  cic_interpolator_variable_ahb #(
    .DW  (DW),
    .N   (N),
    .RMAX(RMAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .tdata_s    (tdata_s),
    .tvalid_s   (tvalid_s),
    .tready_s   (tready_s),
    .tdata_m    (tdata_m),
    .tvalid_m   (tvalid_m),
    .tready_m   (tready_m),
    .haddr_s    (haddr_s),
    .hburst_s   (hburst_s),
    .hsize_s    (hsize_s),
    .htrans_s   (htrans_s),
    .hwdata_s   (hwdata_s),
    .hwrite_s   (hwrite_s),
    .hrdata_s   (hrdata_s),
    .hreadyout_s(hreadyout_s),
    .hresp_s    (hresp_s),
    .hsel_s     (hsel_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: records handshakes and checks that a stalled output holds.
  int     ncyc = 0;
  int     acc_cnt = 0;
  int     acc_t[$];
  int     beat_t[$];
  int     got_q[$];
  bit     chk_stall = 1'b0;
  bit     stall_prev = 1'b0;
  longint prev_data = 0;

  always @(negedge clk) begin
    ncyc++;
    if (tvalid_s && tready_s) begin
      acc_cnt++;
      acc_t.push_back(ncyc);
    end
    if (tvalid_m && tready_m) begin
      got_q.push_back(int'(tdata_m));
      beat_t.push_back(ncyc);
    end
    if (chk_stall && stall_prev) begin
      check("stall_valid", longint'(tvalid_m), 1);
      check("stall_data", longint'(tdata_m), prev_data);
    end
    stall_prev = tvalid_m && !tready_m;
    prev_data  = longint'(tdata_m);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = a;
    tick();
    hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = d;
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b0; haddr_s = a;
    tick();
    hsel_s = 1'b0; htrans_s = 2'b00;
    d = hrdata_s;
    tick();
  endtask

  // Reference: zero-stuffed input convolved with a length-R boxcar N times,
  // then arithmetic shift and saturation.
  longint xin[$];
  int     exp_q[$];

  function automatic void build_model(input int r, input int sh);
    longint h[$];
    longint t[$];
    longint acc;
    int     d;
    exp_q.delete();
    h.push_back(1);
    for (int s = 0; s < N; s++) begin
      t.delete();
      for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      h = t;
    end
    for (int n = 0; n < xin.size() * r; n++) begin
      acc = 0;
      for (int k = 0; k < xin.size(); k++) begin
        d = n - k * r;
        if (d >= 0 && d < h.size()) acc += xin[k] * h[d];
      end
      acc = acc >>> sh;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      exp_q.push_back(int'(acc));
    end
  endfunction

  int got_base;
  int acc_t_base;

  // mode: 0 random data, 1 constant cval, 2 preset xin
  // bpmode: 0 always ready, 1 random, 2 pattern 1-0-0-1; vmode: 0 always valid, 1 random gaps
  task automatic run_stream(input int r, input int sh, input int nin, input int mode,
                            input int cval, input int bpmode, input int vmode);
    logic signed [15:0] rv;
    int acc_base, idx, last_idx, cyc, total;
    ahb_write(32'h4, r);
    ahb_write(32'h8, sh);
    ahb_write(32'h0, 32'h3);
    if (mode != 2) begin
      xin.delete();
      for (int i = 0; i < nin; i++) begin
        rv = 16'($urandom);
        xin.push_back(mode == 1 ? longint'(cval) : longint'(rv));
      end
    end
    build_model(r, sh);
    total      = xin.size() * r;
    got_base   = got_q.size();
    acc_base   = acc_cnt;
    acc_t_base = acc_t.size();
    chk_stall  = 1'b1;
    last_idx   = -1;
    cyc        = 0;
    while ((got_q.size() - got_base) < total && cyc < total * 8 + 200) begin
      idx = acc_cnt - acc_base;
      if (idx < xin.size()) begin
        if (!(tvalid_s && idx == last_idx))
          tvalid_s = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        tdata_s = 16'(xin[idx]);
      end else begin
        tvalid_s = 1'b0;
      end
      last_idx = idx;
      case (bpmode)
        0:       tready_m = 1'b1;
        1:       tready_m = ($urandom_range(0, 3) != 0);
        default: tready_m = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      tick();
      cyc++;
    end
    tvalid_s  = 1'b0;
    tready_m  = 1'b1;
    chk_stall = 1'b0;
    repeat (4) tick();
    check("beat_count", got_q.size() - got_base, total);
    for (int i = 0; i < total; i++)
      if (got_base + i < got_q.size()) check("sample", got_q[got_base+i], exp_q[i]);
  endtask

  function automatic int last_out();
    return (got_q.size() > got_base) ? got_q[got_q.size()-1] : 99999;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t    rv_tab[11];
  logic [31:0] rd;
  int          b0, a0, bad;
  int          imp_exp[8];

  initial begin
    rv_tab[0]  = '{32'h4,   32'd0,      32'd1};
    rv_tab[1]  = '{32'h4,   32'd200,    32'd64};
    rv_tab[2]  = '{32'h4,   32'd64,     32'd64};
    rv_tab[3]  = '{32'h4,   32'd65,     32'd64};
    rv_tab[4]  = '{32'h104, 32'd9,      32'd9};
    rv_tab[5]  = '{32'h8,   32'h3f,     32'h3f};
    rv_tab[6]  = '{32'h8,   32'hff,     32'h3f};
    rv_tab[7]  = '{32'h0,   32'h1,      32'h1};
    rv_tab[8]  = '{32'h0,   32'h3,      32'h1};
    rv_tab[9]  = '{32'h0,   32'h0,      32'h0};
    rv_tab[10] = '{32'hC,   32'hffff,   32'h0};
    imp_exp = '{1, 3, 3, 1, 0, 0, 0, 0};

    repeat (3) tick();
    check("rst_tready_s", tready_s, 0);
    check("rst_tvalid_m", tvalid_m, 0);
    check("rst_tdata_m", tdata_m, 0);
    check("rst_hrdata", hrdata_s, 0);
    check("hreadyout", hreadyout_s, 1);
    check("hresp", hresp_s, 0);
    reset = 1'b0;
    tick();
    ahb_read(32'h4, rd); check("rst_ratio", rd, 1);
    ahb_read(32'h8, rd); check("rst_shift", rd, 0);
    ahb_read(32'h0, rd); check("rst_ctrl", rd, 0);
    ahb_read(32'hC, rd); check("rst_status", rd, 0);

    foreach (rv_tab[i]) begin
      ahb_write(rv_tab[i].addr, rv_tab[i].wdata);
      ahb_read(rv_tab[i].addr, rd);
      check($sformatf("reg_vec%0d", i), rd, rv_tab[i].exp);
    end

    ahb_write(32'h0, 32'h1);
    ce = 1'b0; #1;
    check("ce_low_tready", tready_s, 0);
    ce = 1'b1; #1;
    check("ce_high_tready", tready_s, 1);
    tick();

    // Pass-through, R=1
    xin = '{100, -200, 300};
    run_stream(1, 0, 3, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (got_base + i < got_q.size()) begin
        check("pt_value", got_q[got_base+i], xin[i]);
        check("pt_latency", beat_t[got_base+i] - acc_t[acc_t_base+i], 2);
      end
    end

    // Impulse, R=2
    xin = '{1, 0, 0, 0};
    run_stream(2, 0, 4, 2, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      if (got_base + i < got_q.size()) check("impulse", got_q[got_base+i], imp_exp[i]);
    for (int i = 0; i < 3; i++)
      if (acc_t_base + i + 1 < acc_t.size())
        check("impulse_accept_gap", acc_t[acc_t_base+i+1] - acc_t[acc_t_base+i], 2);

    // DC gain
    run_stream(4, 0, 6, 1, 1000, 0, 0);
    check("dc_gain_shift0", last_out(), 16000);
    run_stream(4, 4, 6, 1, 1000, 0, 0);
    check("dc_gain_shift4", last_out(), 1000);

    // Saturation without wrap
    run_stream(64, 0, 5, 1, 32767, 0, 0);
    check("sat_pos", last_out(), 32767);
    bad = 0;
    for (int i = got_base; i < got_q.size(); i++) if (got_q[i] < 0) bad++;
    check("sat_pos_nowrap", bad, 0);
    run_stream(64, 0, 5, 1, -32768, 0, 0);
    check("sat_neg", last_out(), -32768);
    bad = 0;
    for (int i = got_base; i < got_q.size(); i++) if (got_q[i] > 0) bad++;
    check("sat_neg_nowrap", bad, 0);

    // Backpressure 1-0-0-1
    run_stream(4, 4, 6, 1, 1000, 2, 0);
    check("bp_dc", last_out(), 1000);
    run_stream(4, 2, 8, 0, 0, 2, 1);

    // Random streams
    for (int t = 0; t < 6; t++)
      run_stream(int'($urandom_range(1, 8)), int'($urandom_range(0, 6)), 10, 0, 0, 1, 1);

    // RATIO write mid-sample keeps the old ratio for that sample
    ahb_write(32'h4, 32'd8);
    ahb_write(32'h8, 32'd0);
    ahb_write(32'h0, 32'h3);
    b0 = got_q.size(); a0 = acc_cnt;
    tvalid_s = 1'b1; tdata_s = 16'sd5; tready_m = 1'b1;
    tick();
    tvalid_s = 1'b0;
    check("mr_accept", acc_cnt - a0, 1);
    ahb_write(32'h4, 32'd2);
    repeat (12) tick();
    check("mr_old_ratio_beats", got_q.size() - b0, 8);
    b0 = got_q.size();
    tvalid_s = 1'b1;
    tick();
    tvalid_s = 1'b0;
    repeat (10) tick();
    check("mr_new_ratio_beats", got_q.size() - b0, 2);

    // Clear mid-sequence
    ahb_write(32'h4, 32'd8);
    ahb_write(32'h0, 32'h3);
    b0 = got_q.size();
    tvalid_s = 1'b1; tdata_s = 16'sd1000;
    tick();
    tvalid_s = 1'b0;
    repeat (2) tick();
    ahb_write(32'h0, 32'h3);
    check("clr_tvalid", tvalid_m, 0);
    ahb_read(32'hC, rd); check("clr_status", rd, 0);
    repeat (10) tick();
    check("clr_beats", got_q.size() - b0, 3);
    check("clr_tvalid_late", tvalid_m, 0);

    // Reset mid-stream
    ahb_write(32'h4, 32'd8);
    ahb_write(32'h8, 32'd3);
    ahb_write(32'h0, 32'h3);
    tvalid_s = 1'b1; tdata_s = 16'sd1000;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    tvalid_s = 1'b0;
    check("mrst_tready_s", tready_s, 0);
    check("mrst_tvalid_m", tvalid_m, 0);
    check("mrst_tdata_m", tdata_m, 0);
    check("mrst_hrdata", hrdata_s, 0);
    reset = 1'b0;
    tick();
    b0 = got_q.size();
    ahb_read(32'h0, rd); check("mrst_ctrl", rd, 0);
    ahb_read(32'h4, rd); check("mrst_ratio", rd, 1);
    ahb_read(32'h8, rd); check("mrst_shift", rd, 0);
    ahb_read(32'hC, rd); check("mrst_status", rd, 0);
    repeat (10) tick();
    check("mrst_no_beats", got_q.size() - b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_interpolator_variable_ahb.md
Name: cic_interpolator_variable_ahb

Overview:
- Variable-ratio CIC interpolator. It is the transmit-side counterpart of the variable-ratio CIC decimator.
- Accepts one AXI-Stream sample per input beat and emits R output beats per input, via N comb stages, zero-stuffing and N integrator stages.
- Ratio, output shift and enable are programmed over an AHB-Lite slave port.
- Sits between a sample source and a DAC/upconverter stream path.

Parameters:
- DW, 16, signed sample width on both stream ports.
- N, 3, number of comb stages and number of integrator stages.
- RMAX, 64, maximum interpolation ratio (power of two).
- GW, DW+N*log2(RMAX), internal comb/integrator width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  datapath clock enable; when low, all datapath state freezes; AHB still works.
- tdata_s  in  DW  input sample, signed.
- tvalid_s  in  1  input valid.
- tready_s  out  1  input ready.
- tdata_m  out  DW  output sample, signed.
- tvalid_m  out  1  output valid.
- tready_m  in  1  output ready.
- haddr_s  in  32  AHB address; decode uses [3:2].
- hburst_s  in  3  ignored.
- hsize_s  in  3  ignored; all accesses treated as 32-bit.
- htrans_s  in  2  AHB transfer type.
- hwdata_s  in  32  write data.
- hwrite_s  in  1  write strobe.
- hrdata_s  out  32  read data.
- hreadyout_s  out  1  constant 1 (zero wait state).
- hresp_s  out  1  constant 0 (OKAY).
- hsel_s  in  1  slave select.

Behaviour:
- Reset values: tready_s=0, tvalid_m=0, tdata_m=0, hrdata_s=0, all comb/integrator/phase state=0, CTRL=0, RATIO=1, SHIFT=0.
- AHB access:
  - Address phase is captured when hsel_s & htrans_s[1]. Write data is applied in the following cycle.
  - Reads return in the data phase.
  - Unmapped offsets read 0; writes to them are ignored.
- Register map:
  - 0x0 CTRL: bit0 enable (RW); bit1 clear (WO, self-clearing; zeroes all datapath state in one cycle).
  - 0x4 RATIO: [7:0] R. 0 is stored as 1; values above RMAX are stored as RMAX.
  - 0x8 SHIFT: [5:0] arithmetic right shift applied before saturation.
  - 0xC STATUS (RO): bit0 busy (a comb sample is pending); [15:8] current phase.
- Comb section, input rate:
  - An accepted beat (tvalid_s & tready_s & ce) sign-extends tdata_s to GW and updates all N combs (y = x - x_prev, M=1).
  - The result is registered into comb_out and sets pend=1.
  - R_act latches RATIO at this point, so a RATIO write mid-sample takes effect on the next input.
- Integrator section, output rate:
  - A step occurs when ce & pend & (~tvalid_m | tready_m).
  - Integrator 1 input is comb_out when phase==0, otherwise 0.
  - All N integrators update with wrap-around (modular) GW arithmetic.
  - phase increments. At phase==R_act-1, phase returns to 0 and pend clears, unless a new input is accepted in the same cycle, in which case pend stays 1.
- tready_s = enable & ce & (~pend | last-phase step). This gives gapless streaming when tready_m stays high.
- Output register:
  - On each step, tvalid_m=1 and tdata_m = sat_DW(integrator_N >>> SHIFT).
  - Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
  - tvalid_m clears when tready_m is high and no step occurs.
  - tdata_m/tvalid_m hold while tvalid_m & ~tready_m.
- Latency: the first output beat is valid 2 cycles after input acceptance. Sustained rate is one input per R cycles, R outputs per input.
- DC gain is R^(N-1); SHIFT compensates.
- Disable (enable=0): no new inputs are accepted. A pending sample finishes its remaining phases.
- Simultaneous events:
  - Clear beats any step or accept in the same cycle.
  - reset beats everything.
- Mid-operation reset or clear: the partial output sequence is abandoned; no further tvalid_m until a new input.

Test Plan:
- Pass-through: R=1, SHIFT=0, enable, inputs 100, -200, 300 with tready_m=1 -> outputs 100, -200, 300, each 2 cycles after its input, one per cycle.
- Impulse: R=2, N=3, SHIFT=0, inputs 1, 0, 0, 0 -> output sequence 1, 3, 3, 1, 0, 0, 0, 0. tready_s is high every 2nd cycle.
- DC gain: R=4, constant input 1000 -> steady output 16000 with SHIFT=0; rerun with SHIFT=4 -> steady output 1000.
- Saturation: R=64, SHIFT=0, DC 32767 -> steady 32767; DC -32768 -> steady -32768, with no wrap.
- Backpressure: R=4, DC 1000, SHIFT=4; toggle tready_m 1-0-0-1 -> tdata_m stable while stalled, no beats lost or duplicated, and exactly 4 outputs per accepted input.
- Control:
  - Write RATIO=0 -> reads back 1. Write RATIO=200 -> reads back 64.
  - Write RATIO mid-sample -> the current sample keeps its old R.
  - CTRL clear mid-sequence -> tvalid_m drops, STATUS reads 0.
  - reset asserted mid-stream -> all outputs return to reset values.
